// File: rtl/sar_conv_host.sv
// sar_conv_host: host-side SAR toggle-handshake initiator with oversampled
// rounded averaging, WAIT timeout and sticky status flags.
module sar_conv_host #(
    parameter int NBIT    = 10,
    parameter int OSR_MAX = 4,
    parameter int TIMEOUT = 255,
    parameter int SOC_GAP = 2
) (
    input  logic            f100m_clk,
    input  logic            rst,
    input  logic            start,
    input  logic            stop,
    input  logic            cfg_cont,
    input  logic [2:0]      cfg_osr,
    input  logic            sts_clr,
    output logic            sar_soc,
    input  logic            sar_eoc,
    input  logic            sar_err,
    input  logic            sar_warn,
    input  logic [NBIT-1:0] sar_code,
    output logic            res_valid,
    output logic [NBIT-1:0] res_data,
    output logic            busy,
    output logic            err_flag,
    output logic            tmo_flag,
    output logic [7:0]      warn_cnt
);
    localparam int AW = NBIT + OSR_MAX + 1;
    localparam int CW = OSR_MAX + 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int GW = $clog2(SOC_GAP + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, GAP} state_t;
    state_t state, state_nxt;

    logic          eoc_q, err_q, warn_q;
    logic [2:0]    osr;
    logic          cont, stop_pend;
    logic [AW-1:0] acc, sum, rnd;
    logic [CW-1:0] cnt, cnt_inc;
    logic [TW-1:0] timer;
    logic [GW-1:0] gcnt;
    logic          eoc_tog, err_tog, warn_tog, stop_now, last, tmo, in_wait, res_now;

    assign eoc_tog  = sar_eoc ^ eoc_q;
    assign err_tog  = sar_err ^ err_q;
    assign warn_tog = sar_warn ^ warn_q;
    assign stop_now = stop_pend | stop;
    assign in_wait  = state == WAIT;
    assign sum      = acc + AW'(sar_code);
    assign cnt_inc  = cnt + CW'(1);
    assign last     = cnt_inc == (CW'(1) << osr);
    assign rnd      = (osr == 3'd0) ? '0 : AW'(1) << (osr - 3'd1);
    assign tmo      = timer == TW'(TIMEOUT - 1);
    assign res_now  = in_wait && !err_tog && eoc_tog && last;
    assign busy     = state != IDLE;

    always_ff @(posedge f100m_clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // err outranks eoc, which outranks the timeout
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = start ? ISSUE : IDLE;
            ISSUE:   state_nxt = WAIT;
            WAIT:    state_nxt = err_tog ? IDLE :
                                 eoc_tog ? ((last && !(cont && !stop_now)) ? IDLE : GAP) :
                                 tmo     ? IDLE : WAIT;
            GAP:     state_nxt = stop_now ? IDLE :
                                 (gcnt == GW'(SOC_GAP - 1)) ? ISSUE : GAP;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge f100m_clk) begin
        if (rst) begin
            eoc_q     <= 1'b0;
            err_q     <= 1'b0;
            warn_q    <= 1'b0;
            osr       <= '0;
            cont      <= 1'b0;
            stop_pend <= 1'b0;
            acc       <= '0;
            cnt       <= '0;
            timer     <= '0;
            gcnt      <= '0;
            sar_soc   <= 1'b0;
            res_valid <= 1'b0;
            res_data  <= '0;
            err_flag  <= 1'b0;
            tmo_flag  <= 1'b0;
            warn_cnt  <= '0;
        end else begin
            eoc_q     <= sar_eoc;
            err_q     <= sar_err;
            warn_q    <= sar_warn;
            stop_pend <= (state_nxt == IDLE) ? 1'b0 : (busy && stop) ? 1'b1 : stop_pend;
            gcnt      <= (state == GAP) ? gcnt + GW'(1) : '0;
            timer     <= in_wait ? timer + TW'(1) : '0;
            res_valid <= res_now;
            if (res_now) res_data <= NBIT'((sum + rnd) >> osr);
            if (state == IDLE && start) begin
                osr  <= (cfg_osr > 3'(OSR_MAX)) ? 3'(OSR_MAX) : cfg_osr;
                cont <= cfg_cont;
                acc  <= '0;
                cnt  <= '0;
            end else if (in_wait && eoc_tog && !err_tog) begin
                acc <= last ? '0 : sum;
                cnt <= last ? '0 : cnt_inc;
            end
            if (state == ISSUE) sar_soc <= ~sar_soc;
            err_flag <= (in_wait && err_tog) | (err_flag & ~sts_clr);
            tmo_flag <= (in_wait && !err_tog && !eoc_tog && tmo) | (tmo_flag & ~sts_clr);
            warn_cnt <= warn_tog ? ((&warn_cnt) ? warn_cnt : warn_cnt + 8'd1) :
                        sts_clr  ? '0 : warn_cnt;
        end
    end
endmodule

// File: tb/tb_sar_conv_host.sv
// tb_sar_conv_host: randomized scoreboard bench with a behavioural SAR model
// and an averaging reference computed from plain arithmetic.
module tb_sar_conv_host;
    localparam int NBIT = 10, OSR_MAX = 4, TIMEOUT = 255, SOC_GAP = 2;

    logic f100m_clk = 0, rst = 1, start = 0, stop = 0, cfg_cont = 0, sts_clr = 0;
    logic sar_eoc = 0, sar_err = 0, sar_warn = 0;
    logic [2:0] cfg_osr = 0;
    logic [NBIT-1:0] sar_code = 0;
    logic sar_soc, res_valid, busy, err_flag, tmo_flag;
    logic [NBIT-1:0] res_data;
    logic [7:0] warn_cnt;

    int errors = 0, checks = 0, cyc = 0, soc_cnt = 0, res_cnt = 0, soc_cyc = 0;
    int last_eoc_cyc = -100, mode = 0, lat = 0;
    int exp_q[$], code_q[$], fix_q[$];

    always #5 f100m_clk = ~f100m_clk;
    always @(posedge f100m_clk) cyc <= cyc + 1;

    sar_conv_host #(.NBIT(NBIT), .OSR_MAX(OSR_MAX), .TIMEOUT(TIMEOUT), .SOC_GAP(SOC_GAP)) dut (
        .f100m_clk(f100m_clk), .rst(rst), .start(start), .stop(stop), .cfg_cont(cfg_cont),
        .cfg_osr(cfg_osr), .sts_clr(sts_clr), .sar_soc(sar_soc), .sar_eoc(sar_eoc),
        .sar_err(sar_err), .sar_warn(sar_warn), .sar_code(sar_code), .res_valid(res_valid),
        .res_data(res_data), .busy(busy), .err_flag(err_flag), .tmo_flag(tmo_flag),
        .warn_cnt(warn_cnt)
    );

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", nm, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(negedge f100m_clk);
    endtask

    task automatic wait_idle(input string nm);
        int t = 0;
        while (busy && t < 4000) begin tick(); t++; end
        check(nm, int'(busy), 0);
    endtask

    task automatic pulse_start(input int osr, input bit cont);
        cfg_osr = 3'(osr); cfg_cont = cont; start = 1;
        tick();
        start = 0;
    endtask

    task automatic pulse_clr();
        sts_clr = 1; tick(); sts_clr = 0;
    endtask

    // mode 0: eoc after latency, 1: SAR silent, 2: err and eoc toggle together
    initial begin
        logic seen;
        seen = 0;
        forever begin
            tick();
            if (sar_soc !== seen) begin
                seen = sar_soc;
                soc_cnt++;
                soc_cyc = cyc;
                if (last_eoc_cyc >= 0 && !rst) check("soc_gap", int'(cyc - last_eoc_cyc > SOC_GAP), 1);
                if (mode != 1 && !rst) begin
                    tick(lat != 0 ? lat : int'($urandom_range(1, 8)));
                    sar_code = NBIT'(code_q.size() != 0 ? code_q.pop_front() : int'($urandom_range(0, 1023)));
                    if (mode == 2) sar_err = ~sar_err;
                    sar_eoc = ~sar_eoc;
                    last_eoc_cyc = cyc;
                    tick();
                    sar_code = NBIT'($urandom);
                end
            end
        end
    end

    always @(negedge f100m_clk) begin
        if (!rst && res_valid) begin
            res_cnt++;
            check("res_lat", cyc - last_eoc_cyc, 1);
            if (exp_q.size() == 0) check("res_unexpected", int'(res_data), -1);
            else check("res_data", int'(res_data), exp_q.pop_front());
        end
    end

    // one start; in continuous mode stop lands in the first conversion of result nres
    task automatic run(input int osr_cfg, input bit cont, input int nres);
        int eff = osr_cfg > OSR_MAX ? OSR_MAX : osr_cfg;
        int n = 1 << eff;
        int done = !cont ? 1 : (eff == 0 ? nres : nres - 1);
        int exp_soc = !cont ? n : (eff == 0 ? nres : done * n + 1);
        int r0 = res_cnt, s0 = soc_cnt, s1, t = 0, sum, c, last_exp = 0;
        for (int r = 0; r < done; r++) begin
            sum = 0;
            for (int k = 0; k < n; k++) begin
                c = fix_q.size() != 0 ? fix_q.pop_front() : int'($urandom_range(0, 1023));
                code_q.push_back(c);
                sum += c;
            end
            last_exp = (sum + n / 2) / n;
            exp_q.push_back(last_exp);
        end
        pulse_start(osr_cfg, cont);
        if (cont) begin
            while (res_cnt < r0 + nres - 1 && t < 4000) begin tick(); t++; end
            s1 = soc_cnt;
            while (soc_cnt == s1 && t < 4000) begin tick(); t++; end
            check("stop_arm", int'(t < 4000), 1);
            stop = 1; tick(); stop = 0;
        end
        wait_idle("idle");
        tick(4);
        check("res_count", res_cnt - r0, done);
        check("soc_count", soc_cnt - s0, exp_soc);
        check("drain", exp_q.size(), 0);
        if (done > 0) check("res_hold", int'(res_data), last_exp);
    endtask

    initial begin
        int r0, s0, t;
        tick(3);
        check("rst_ctrl", int'({sar_soc, res_valid, busy, err_flag, tmo_flag}), 0);
        check("rst_data", int'(res_data), 0);
        check("rst_warn", int'(warn_cnt), 0);
        rst = 0;
        tick(2);

        lat = 6; fix_q = '{341}; run(0, 0, 1);
        lat = 0; fix_q = '{100, 101, 101, 102}; run(2, 0, 1);
        repeat (16) fix_q.push_back(1023);
        run(7, 0, 1);
        lat = 4; run(0, 1, 3);
        lat = 0;
        repeat (6) run(int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), int'($urandom_range(1, 3)));

        mode = 1; r0 = res_cnt; s0 = soc_cnt; t = 0;
        check("tmo_pre", int'(tmo_flag), 0);
        pulse_start(0, 0);
        while (soc_cnt == s0 && t < 50) begin tick(); t++; end
        while (!tmo_flag && t < 1000) begin tick(); t++; end
        check("tmo_lat", cyc - soc_cyc, TIMEOUT);
        wait_idle("tmo_idle");
        check("tmo_nores", res_cnt - r0, 0);
        mode = 0; run(0, 0, 1);
        check("tmo_sticky", int'(tmo_flag), 1);
        pulse_clr();
        check("tmo_clr", int'(tmo_flag), 0);

        mode = 2; r0 = res_cnt;
        pulse_start(0, 0);
        wait_idle("err_idle");
        tick(2);
        check("err_flag", int'(err_flag), 1);
        check("err_nores", res_cnt - r0, 0);
        mode = 0;
        pulse_clr();
        check("err_clr", int'(err_flag), 0);

        repeat (3) begin sar_warn = ~sar_warn; tick(2); end
        check("warn3", int'(warn_cnt), 3);
        repeat (262) begin sar_warn = ~sar_warn; tick(); end
        tick();
        check("warn_sat", int'(warn_cnt), 255);
        pulse_clr();
        check("warn_clr", int'(warn_cnt), 0);
        sar_warn = ~sar_warn; tick(2);

        mode = 1; s0 = soc_cnt; t = 0;
        pulse_start(0, 0);
        while (soc_cnt == s0 && t < 50) begin tick(); t++; end
        tick(3);
        check("busy_wait", int'(busy), 1);
        rst = 1; tick();
        check("mid_rst_ctrl", int'({sar_soc, res_valid, busy, err_flag, tmo_flag}), 0);
        check("mid_rst_data", int'(res_data), 0);
        check("mid_rst_warn", int'(warn_cnt), 0);
        rst = 0; mode = 0; tick(2);
        run(1, 0, 1);

        tick(5);
        check("final_drain", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1);
    end
endmodule
